uart_rom_tx: RTL and testbench
==============================

# uart_rom_tx

Serial UART 8N1 transmitter that dumps the instruction ROM back to the host over a single TX line. It is the transmit-side counterpart of the UART instruction loader in `sm_top`. It uses the same bit period and the same word framing: four bytes per word, most-significant byte first, each byte sent LSB-first. On a start request it walks ROM addresses 0..WORDS-1, reads each word through the ROM read port, and serialises it, so a bench or host can verify what was loaded.

## Interface
Parameters:
- `CLKS_PER_BIT`, 870: clock cycles per UART bit; minimum legal value is 2.
- `WORDS`, 16: number of ROM words dumped per request.
- `ADDR_W`, 5: width of the ROM address port; must satisfy WORDS <= 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start_i`  in  1  dump request; sampled only in IDLE.
- `rom_addr_o`  out  ADDR_W  ROM read address; the ROM read is combinational (`romAddr` -> `romData`).
- `rom_data_i`  in  32  ROM read data for `rom_addr_o`.
- `uart_tx_o`  out  1  serial line; idle level is 1.
- `busy_o`  out  1  high from the cycle after `start_i` is accepted until the dump finishes.
- `done_o`  out  1  one-cycle pulse when the last stop bit of the last word completes.

## Operation
- States:
  - IDLE: `uart_tx_o`=1, `busy_o`=0. `start_i`=1 moves to LOAD.
  - LOAD: one cycle. Latches `rom_data_i` into the 32-bit word register, sets byte_idx=0, then goes to START.
  - START: drives 0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: sends 8 bits of the current byte, LSB first, each held for CLKS_PER_BIT cycles, then goes to STOP.
  - STOP: drives 1 for CLKS_PER_BIT cycles, then:
    - if byte_idx<3: byte_idx+1, go to START (no idle gap between bytes);
    - else if addr==WORDS-1: go to IDLE, pulse `done_o`, addr=0;
    - else: addr+1, go to LOAD.
- Current byte = word[31-8*byte_idx -: 8]. Byte order is [31:24], [23:16], [15:8], [7:0].
- `rom_addr_o` holds the current word address from LOAD through that word's last STOP. It is 0 in IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Bit counter: 0..7 in DATA.
- The address counter is ADDR_W bits wide and never exceeds WORDS-1; there is no wrap past WORDS.
- `start_i` is ignored while `busy_o`=1; requests are not queued.
- ROM contents changing during a dump affect only words not yet latched in LOAD.

## Timing
- Reset values: state IDLE, `uart_tx_o`=1, `busy_o`=0, `done_o`=0, `rom_addr_o`=0, all counters 0.
- Reset mid-operation: on the next edge all outputs return to their reset values. A partially sent frame is abandoned and the line returns high.
- Start latency:
  - `start_i` high at edge k: LOAD is active after edge k, and `busy_o`=1 after edge k.
  - The word is latched at edge k+1, and `uart_tx_o` falls after edge k+1.
- Byte duration: exactly 10*CLKS_PER_BIT cycles.
- Word duration: 1 + 40*CLKS_PER_BIT cycles.
- Full dump: WORDS*(1+40*CPB) cycles from the first LOAD to `done_o`.
- `done_o` is high for exactly one cycle, the first IDLE cycle. `busy_o` is 0 in that same cycle.
- `start_i` high during the `done_o` cycle is accepted and starts a new dump from address 0.
- `uart_tx_o` is registered and glitch-free; every output is a flop.

## Test plan
- Reset / idle:
  - stimulus: assert `rst` for 3 cycles with `start_i`=0, then hold idle for 100 cycles;
  - response: `uart_tx_o`=1, `busy_o`=0, `done_o`=0, `rom_addr_o`=0 throughout.
- Single-word frame (CPB=4, WORDS=1, ROM[0]=0x12345678):
  - byte sequence is 0x12, 0x34, 0x56, 0x78;
  - the first frame's line bits are 0,0,1,0,0,1,0,0,0,1, each held 4 cycles;
  - `done_o` pulses 161 cycles after the LOAD cycle.
- Full dump (CPB=870, WORDS=16, ROM[i]=0xA5000000+i):
  - a bench UART receiver decodes 64 bytes in address order;
  - `rom_addr_o` steps 0..15;
  - `done_o` fires once, 16*34801 cycles after the first LOAD.
- Request while busy:
  - stimulus: pulse `start_i` in the middle of word 3;
  - response: no restart, address sequence unaffected, exactly one `done_o`.
- Back-to-back dumps:
  - stimulus: hold `start_i`=1 through the `done_o` cycle;
  - response: a second dump starts at addr 0 in the next cycle, with no extra idle-high gap beyond the LOAD cycle.
- Reset mid-frame:
  - stimulus: assert `rst` during a DATA bit of byte 2, then release it and pulse `start_i`;
  - response: the line goes high at the next edge, `busy_o`=0, and the new dump begins at addr 0, byte 0.

Source files
------------

// File: rtl/uart_rom_tx.sv
// UART 8N1 transmitter that streams ROM words 0..WORDS-1 on one TX line,
// most-significant byte first, each byte LSB first.
module uart_rom_tx #(
  parameter int unsigned CLKS_PER_BIT = 870,
  parameter int unsigned WORDS        = 16,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

  state_e            state;
  logic [31:0]       word;
  logic [1:0]        byteIdx;
  logic [2:0]        bitIdx;
  logic [TimerW-1:0] timer;
  logic [ADDR_W-1:0] addr;
  logic              tx;
  logic              busy;
  logic              done;

  logic [7:0]        curByte;
  logic [2:0]        bitNext;
  logic              bitEnd;

  always_comb begin
    curByte = word[31:24];
    unique case (byteIdx)
      2'd0: curByte = word[31:24];
      2'd1: curByte = word[23:16];
      2'd2: curByte = word[15:8];
      2'd3: curByte = word[7:0];
    endcase
  end

  assign bitNext = bitIdx + 3'd1;
  assign bitEnd  = (timer == TimerMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      word    <= '0;
      byteIdx <= '0;
      bitIdx  <= '0;
      timer   <= '0;
      addr    <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_i) begin
            state <= StLoad;
            busy  <= 1'b1;
            addr  <= '0;
          end
        end
        StLoad: begin
          word    <= rom_data_i;
          byteIdx <= '0;
          timer   <= '0;
          tx      <= 1'b0;
          state   <= StStart;
        end
        StStart: begin
          if (bitEnd) begin
            timer  <= '0;
            bitIdx <= '0;
            tx     <= curByte[0];
            state  <= StData;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StData: begin
          if (bitEnd) begin
            timer <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= StStop;
            end else begin
              bitIdx <= bitNext;
              tx     <= curByte[bitNext];
            end
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StStop: begin
          if (bitEnd) begin
            timer <= '0;
            if (byteIdx != 2'd3) begin
              // Next byte of the same word follows with no idle gap.
              byteIdx <= byteIdx + 2'd1;
              tx      <= 1'b0;
              state   <= StStart;
            end else if (addr == LastAddr) begin
              state <= StIdle;
              busy  <= 1'b0;
              done  <= 1'b1;
              addr  <= '0;
            end else begin
              addr  <= addr + ADDR_W'(1);
              state <= StLoad;
            end
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign rom_addr_o = addr;
  assign uart_tx_o  = tx;
  assign busy_o     = busy;
  assign done_o     = done;

endmodule

// File: tb/tb_uart_rom_tx.sv
// Bench for uart_rom_tx: byte scoreboard fed at dump start, drained by a bench UART receiver.
module tb_uart_rom_tx;

  localparam int unsigned CPB      = 4;
  localparam int unsigned WORDS    = 16;
  localparam int unsigned AW       = 5;
  localparam int unsigned WORD_CYC = 1 + 40 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startI = 1'b0;
  logic [AW-1:0] romAddr;
  logic [31:0]   romData;
  logic          tx;
  logic          busy;
  logic          done;

  logic [31:0]   rom [WORDS];
  logic [7:0]    expQ [$];
  int            errors = 0;
  int            checks = 0;
  longint        cyc = 0;
  int            addrSteps = 0;
  int            doneCount = 0;
  logic [AW-1:0] lastAddr = '0;
  logic [9:0]    firstFrame = 10'b1000100100;

  uart_rom_tx #(
    .CLKS_PER_BIT(CPB),
    .WORDS       (WORDS),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (startI),
    .rom_addr_o(romAddr),
    .rom_data_i(romData),
    .uart_tx_o (tx),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign romData = (romAddr < AW'(WORDS)) ? rom[romAddr[3:0]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench UART receiver: samples mid-bit and pops the scoreboard per byte.
  initial begin
    logic       rxOn;
    int         rxCnt;
    logic [7:0] rxSh;
    logic [7:0] expB;
    rxOn = 1'b0;
    rxCnt = 0;
    rxSh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rxOn = 1'b0;
      end else if (!rxOn) begin
        if (tx === 1'b0) begin
          rxOn = 1'b1;
          rxCnt = 0;
        end
      end else begin
        rxCnt++;
        if (rxCnt == CPB / 2) begin
          check("rx_start_bit", {31'd0, tx}, 32'd0);
        end else if (rxCnt >= CPB + CPB / 2 && rxCnt <= 8 * CPB + CPB / 2 &&
                     (rxCnt - CPB / 2) % CPB == 0) begin
          rxSh = {tx, rxSh[7:1]};
        end else if (rxCnt == 9 * CPB + CPB / 2) begin
          check("rx_stop_bit", {31'd0, tx}, 32'd1);
          check("rx_byte_expected", {31'd0, expQ.size() != 0}, 32'd1);
          if (expQ.size() != 0) begin
            expB = expQ.pop_front();
            check("rx_byte", {24'd0, rxSh}, {24'd0, expB});
          end
          rxOn = 1'b0;
        end
      end
    end
  end

  // Address monitor: every non-zero address change must be a +1 step.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && romAddr !== lastAddr) begin
        if (romAddr != '0) begin
          check("addr_step", {27'd0, romAddr}, {27'd0, lastAddr + AW'(1)});
          addrSteps++;
        end
      end
      lastAddr = romAddr;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic pushDump();
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 3; b >= 0; b--) expQ.push_back(rom[w][8*b +: 8]);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the LOAD-cycle negedge.
  task automatic startDump(input string tag, output longint loadCyc);
    startI = 1'b1;
    pushDump();
    addrSteps = 0;
    doneCount = 0;
    @(negedge clk);
    startI = 1'b0;
    check({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
    check({tag, "_addr_load"}, {27'd0, romAddr}, 32'd0);
    check({tag, "_tx_load"}, {31'd0, tx}, 32'd1);
    loadCyc = cyc;
  endtask

  task automatic checkFirstFrame(input string tag);
    for (int j = 0; j < 10 * CPB; j++) begin
      @(negedge clk);
      check({tag, "_frame_bit"}, {31'd0, tx}, {31'd0, firstFrame[j / CPB]});
    end
  endtask

  // Returns at the negedge of the done cycle.
  task automatic waitDone(input string tag, input longint loadCyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < WORDS * WORD_CYC + 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_done_time"}, 32'(cyc - loadCyc), 32'(WORDS * WORD_CYC));
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_tx_at_done"}, {31'd0, tx}, 32'd1);
    check({tag, "_addr_steps"}, 32'(addrSteps), 32'(WORDS - 1));
    check({tag, "_bytes_left"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic endDump(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_done_count"}, 32'(doneCount), 32'd1);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr_idle"}, {27'd0, romAddr}, 32'd0);
  endtask

  initial begin
    longint ld;
    int     n;
    for (int i = 0; i < WORDS; i++) rom[i] = (i == 0) ? 32'h1234_5678 : 32'hA500_0000 + 32'(i);

    rst = 1'b1;
    startI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_addr", {27'd0, romAddr}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_addr", {27'd0, romAddr}, 32'd0);
    end

    // Full dump with first-frame line check.
    startDump("dumpA", ld);
    checkFirstFrame("dumpA");
    waitDone("dumpA", ld);
    endDump("dumpA");
    repeat (5) @(negedge clk);

    // Request while busy, in the middle of word 3.
    startDump("busyReq", ld);
    n = 0;
    while (romAddr !== AW'(3) && n < 4 * WORD_CYC) begin
      @(negedge clk);
      n++;
    end
    check("busyReq_reach_word3", {27'd0, romAddr}, 32'd3);
    repeat (60) @(negedge clk);
    startI = 1'b1;
    @(negedge clk);
    startI = 1'b0;
    check("busyReq_still_busy", {31'd0, busy}, 32'd1);
    check("busyReq_addr_kept", {27'd0, romAddr}, 32'd3);
    waitDone("busyReq", ld);
    endDump("busyReq");
    repeat (5) @(negedge clk);

    // Back-to-back: start held through the done cycle.
    startDump("b2bFirst", ld);
    startI = 1'b1;
    waitDone("b2bFirst", ld);
    pushDump();
    @(negedge clk);
    startI = 1'b0;
    check("b2b_done_count", 32'(doneCount), 32'd1);
    check("b2b_busy_restart", {31'd0, busy}, 32'd1);
    check("b2b_addr_restart", {27'd0, romAddr}, 32'd0);
    check("b2b_tx_load", {31'd0, tx}, 32'd1);
    ld = cyc;
    addrSteps = 0;
    doneCount = 0;
    checkFirstFrame("b2bSecond");
    waitDone("b2bSecond", ld);
    endDump("b2bSecond");
    repeat (5) @(negedge clk);

    // Reset during DATA bit 2 of byte 2 of word 0.
    startDump("rstMid", ld);
    repeat (1 + 23 * CPB + 1) @(negedge clk);
    check("rstMid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstMid_tx", {31'd0, tx}, 32'd1);
    check("rstMid_busy", {31'd0, busy}, 32'd0);
    check("rstMid_done", {31'd0, done}, 32'd0);
    check("rstMid_addr", {27'd0, romAddr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    check("rstMid_idle_tx", {31'd0, tx}, 32'd1);
    startDump("afterRst", ld);
    checkFirstFrame("afterRst");
    waitDone("afterRst", ld);
    endDump("afterRst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
